// File: rtl/decode_pkg.sv
// Shared definitions for the decode/execute boundary: register index width,
// decoded-bundle field layout and the canonical NOP bundle.
package decode_pkg;

  localparam int REG_W_DEF = 5;
  localparam int BUNDLE_W  = 128;

  // Field layout of the decoded bundle (LSB offsets and widths).
  localparam int OPC_LSB    = 0;
  localparam int OPC_W      = 7;
  localparam int FUNCT3_LSB = 7;
  localparam int FUNCT3_W   = 3;
  localparam int ALU_OP_LSB = 10;
  localparam int ALU_OP_W   = 4;
  localparam int FLAGS_LSB  = 14;
  localparam int FLAGS_W    = 8;
  localparam int IMM_LSB    = 22;
  localparam int IMM_W      = 32;
  localparam int PC_LSB     = 54;
  localparam int PC_W       = 32;
  localparam int RSVD_LSB   = 86;
  localparam int RSVD_W     = BUNDLE_W - RSVD_LSB;

  localparam logic [OPC_W-1:0]   OPC_OP_IMM  = 7'b0010011;
  localparam logic [FLAGS_W-1:0] FLAG_ALU_EN = 8'h01;
  localparam logic [FLAGS_W-1:0] FLAG_MEM_RD = 8'h02;
  localparam logic [FLAGS_W-1:0] FLAG_MEM_WR = 8'h04;
  localparam logic [FLAGS_W-1:0] FLAG_BRANCH = 8'h08;
  localparam logic [FLAGS_W-1:0] FLAG_WB_EN  = 8'h10;

  // addi x0, x0, 0: ALU add of zero into x0, no writeback, no memory access.
  function automatic logic [BUNDLE_W-1:0] make_nop();
    logic [BUNDLE_W-1:0] b;
    b = '0;
    b[OPC_LSB +: OPC_W]     = OPC_OP_IMM;
    b[FLAGS_LSB +: FLAGS_W] = FLAG_ALU_EN;
    return b;
  endfunction

  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = make_nop();

endpackage

// File: rtl/load_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load issues and
// cleared on its writeback; a same-cycle set beats the clear. x0 never pends.
module load_scoreboard
  import decode_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_rd_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_rd_i,
  input  logic [REG_W-1:0] look_a_i,
  output logic             look_a_pend_o,
  input  logic [REG_W-1:0] look_b_i,
  output logic             look_b_pend_o
);

  localparam int NREG = 2 ** REG_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_rd_i] = 1'b0;
    end
    if (set_i && (set_rd_i != '0)) begin
      pending_d[set_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Lookups see registered state only, so a writeback unblocks next cycle.
  assign look_a_pend_o = pending_q[look_a_i];
  assign look_b_pend_o = pending_q[look_b_i];

endmodule

// File: rtl/decode_issue_buffer.sv
// DEPTH-entry decode->execute issue FIFO, 1-cycle minimum latency; head is held
// while it reads a register with a load still in flight. Full refuses pushes.
module decode_issue_buffer
  import decode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = BUNDLE_W,
  parameter int REG_W     = REG_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [PAYLOAD_W-1:0]   in_payload_i,
  input  logic [REG_W-1:0]       in_rs1_i,
  input  logic [REG_W-1:0]       in_rs2_i,
  input  logic                   in_read_rs1_i,
  input  logic                   in_read_rs2_i,
  input  logic [REG_W-1:0]       in_rd_i,
  input  logic                   in_load_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PAYLOAD_W-1:0]   out_payload_o,
  output logic [REG_W-1:0]       out_rd_o,
  input  logic                   ld_done_i,
  input  logic [REG_W-1:0]       ld_done_rd_i,
  input  logic                   flush_i,
  output logic                   hazard_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic                 read_rs1;
    logic                 read_rs2;
    logic                 load;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             in_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty;
  logic               push;
  logic               pop;
  logic               rs1_pend;
  logic               rs2_pend;

  assign in_entry = '{
    payload:  in_payload_i,
    rs1:      in_rs1_i,
    rs2:      in_rs2_i,
    rd:       in_rd_i,
    read_rs1: in_read_rs1_i,
    read_rs2: in_read_rs2_i,
    load:     in_load_i
  };

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

  // Ready looks only at the registered count: a full buffer refuses a push
  // even when the head pops in the same cycle.
  assign in_ready_o  = (count_q < CNT_W'(DEPTH));
  assign hazard_o    = !empty && ((head.read_rs1 && rs1_pend) || (head.read_rs2 && rs2_pend));
  assign out_valid_o = !empty && !hazard_o;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  assign out_payload_o = empty ? PAYLOAD_W'(NOP_BUNDLE) : head.payload;
  assign out_rd_o      = head.rd;
  assign count_o       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  load_scoreboard #(
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_i         (pop && head.load),
    .set_rd_i      (head.rd),
    .clr_i         (ld_done_i),
    .clr_rd_i      (ld_done_rd_i),
    .look_a_i      (head.rs1),
    .look_a_pend_o (rs1_pend),
    .look_b_i      (head.rs2),
    .look_b_pend_o (rs2_pend)
  );

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Randomised + directed bench for decode_issue_buffer (DEPTH=4) with a
// queue-based reference model and a decoupled output scoreboard.
module tb_decode_issue_buffer;

  localparam int DEPTH = 4;
  localparam int PW    = 128;
  localparam int RW    = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] in_payload_i;
  logic [RW-1:0] in_rs1_i, in_rs2_i, in_rd_i;
  logic          in_read_rs1_i, in_read_rs2_i, in_load_i;
  logic          out_valid_o, out_ready_i;
  logic [PW-1:0] out_payload_o;
  logic [RW-1:0] out_rd_o;
  logic          ld_done_i;
  logic [RW-1:0] ld_done_rd_i;
  logic          flush_i;
  logic          hazard_o;
  logic [$clog2(DEPTH):0] count_o;

  decode_issue_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .REG_W(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_payload_i(in_payload_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
    .in_read_rs1_i(in_read_rs1_i), .in_read_rs2_i(in_read_rs2_i),
    .in_rd_i(in_rd_i), .in_load_i(in_load_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_payload_o(out_payload_o), .out_rd_o(out_rd_o),
    .ld_done_i(ld_done_i), .ld_done_rd_i(ld_done_rd_i),
    .flush_i(flush_i), .hazard_o(hazard_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PW-1:0] pay;
    logic [RW-1:0] rs1, rs2, rd;
    bit            r1, r2, ld;
  } ent_t;

  ent_t mdl_q[$];   // model of buffer contents
  ent_t exp_q[$];   // expected issue order, consumed by the monitor
  bit   pend [32];
  bit   started = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: advances once per cycle from the spec's rules.
  task automatic model_step();
    int   cnt;
    bit   hz, ov, ir, push, pop;
    ent_t h, e;
    cnt = mdl_q.size();
    hz  = 0;
    if (cnt > 0) begin
      h  = mdl_q[0];
      hz = (h.r1 && pend[h.rs1]) || (h.r2 && pend[h.rs2]);
    end
    ov = (cnt > 0) && !hz;
    ir = cnt < DEPTH;
    chk("count", 128'(count_o), 128'(cnt));
    chk("in_ready", 128'(in_ready_o), 128'(ir));
    chk("out_valid", 128'(out_valid_o), 128'(ov));
    chk("hazard", 128'(hazard_o), 128'(hz));
    if (rst_i) begin
      mdl_q.delete();
      exp_q.delete();
      foreach (pend[i]) pend[i] = 0;
      return;
    end
    pop  = !flush_i && ov && out_ready_i;
    push = !flush_i && in_valid_i && ir;
    if (ld_done_i) pend[ld_done_rd_i] = 0;
    if (pop && h.ld && h.rd != 0) pend[h.rd] = 1;
    if (flush_i) begin
      mdl_q.delete();
      exp_q.delete();
    end else begin
      if (pop) void'(mdl_q.pop_front());
      if (push) begin
        e.pay = in_payload_i; e.rs1 = in_rs1_i; e.rs2 = in_rs2_i; e.rd = in_rd_i;
        e.r1 = in_read_rs1_i; e.r2 = in_read_rs2_i; e.ld = in_load_i;
        mdl_q.push_back(e);
        exp_q.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    if (started) model_step();
  end

  // Monitor: whenever the head is offered, it must be the oldest expected bundle.
  initial forever begin
    @(negedge clk_i);
    if (started && !rst_i && !flush_i && out_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: out_valid with nothing expected at %0t", $time);
      end else begin
        chk("payload", out_payload_o, exp_q[0].pay);
        chk("out_rd", 128'(out_rd_o), 128'(exp_q[0].rd));
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic no_push();
    in_valid_i = 0; in_read_rs1_i = 0; in_read_rs2_i = 0; in_load_i = 0;
  endtask

  task automatic put(logic [RW-1:0] rs1, bit r1, logic [RW-1:0] rs2, bit r2,
                     logic [RW-1:0] rd, bit ld);
    in_valid_i    = 1;
    in_payload_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_rs1_i      = rs1; in_read_rs1_i = r1;
    in_rs2_i      = rs2; in_read_rs2_i = r2;
    in_rd_i       = rd;  in_load_i     = ld;
  endtask

  task automatic done(logic [RW-1:0] rd);
    ld_done_i = 1; ld_done_rd_i = rd;
    step();
    ld_done_i = 0;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; out_ready_i = 0; ld_done_i = 0; ld_done_rd_i = 0;
    in_payload_i = '0; in_rs1_i = 0; in_rs2_i = 0; in_rd_i = 0;
    no_push();
    step();
    started = 1;
    step();
    rst_i = 0;
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_hazard", 128'(hazard_o), 128'(0));

    // Fill past capacity with execute stalled, then drain in order.
    for (int i = 0; i < 5; i++) begin
      put(0, 0, 0, 0, RW'(i + 1), 0);
      step();
    end
    chk("fill_count", 128'(count_o), 128'(4));
    chk("fill_ready", 128'(in_ready_o), 128'(0));
    no_push();
    out_ready_i = 1;
    repeat (4) step();
    chk("drain_count", 128'(count_o), 128'(0));

    // Simultaneous push/pop at count 2, then at count 4.
    out_ready_i = 0;
    repeat (2) begin put(0, 0, 0, 0, 1, 0); step(); end
    out_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      put(0, 0, 0, 0, RW'(i + 2), 0);
      step();
      chk("pushpop2_count", 128'(count_o), 128'(2));
    end
    out_ready_i = 0;
    repeat (2) begin put(0, 0, 0, 0, 9, 0); step(); end
    out_ready_i = 1;
    put(0, 0, 0, 0, 10, 0);
    step();
    chk("pushpop4_count", 128'(count_o), 128'(3));
    no_push();
    repeat (3) step();

    // Load-use stall on x5, released one cycle after writeback.
    put(0, 0, 0, 0, 5, 1); step();
    put(5, 1, 0, 0, 6, 0); step();
    no_push();
    chk("ldu_hazard", 128'(hazard_o), 128'(1));
    chk("ldu_valid", 128'(out_valid_o), 128'(0));
    repeat (3) step();
    chk("ldu_hold", 128'(hazard_o), 128'(1));
    done(5);
    chk("ldu_release", 128'(out_valid_o), 128'(1));
    step();
    // Load to x0 never blocks.
    put(0, 0, 0, 0, 0, 1); step();
    put(0, 1, 0, 1, 1, 0); step();
    no_push();
    chk("x0_hazard", 128'(hazard_o), 128'(0));
    chk("x0_valid", 128'(out_valid_o), 128'(1));
    step();

    // Set/clear collision on x7: set wins.
    put(0, 0, 0, 0, 7, 1); step();
    no_push(); step();
    put(0, 0, 0, 0, 7, 1); step();
    ld_done_i = 1; ld_done_rd_i = 7;
    put(7, 1, 0, 0, 8, 0); step();
    ld_done_i = 0;
    no_push();
    chk("coll_hazard", 128'(hazard_o), 128'(1));
    step();
    done(7);
    chk("coll_release", 128'(out_valid_o), 128'(1));
    step();

    // Flush with outstanding load to x3; flushed head load to x10 never issues.
    put(0, 0, 0, 0, 3, 1); step();
    no_push(); step();
    out_ready_i = 0;
    put(0, 0, 0, 0, 10, 1); step();
    put(3, 1, 0, 0, 11, 0); step();
    put(0, 0, 0, 0, 12, 0); step();
    chk("pre_flush_count", 128'(count_o), 128'(3));
    out_ready_i = 1; flush_i = 1;
    put(0, 0, 0, 0, 13, 0); step();
    flush_i = 0; no_push();
    chk("flush_count", 128'(count_o), 128'(0));
    chk("flush_valid", 128'(out_valid_o), 128'(0));
    put(0, 0, 3, 1, 14, 0); step();
    no_push();
    chk("flush_ld_hazard", 128'(hazard_o), 128'(1));
    step();
    done(3);
    step();
    put(10, 1, 0, 0, 15, 0); step();
    no_push();
    chk("flush_nopend", 128'(out_valid_o), 128'(1));
    step();

    // Reset with two entries and x4 pending.
    put(0, 0, 0, 0, 4, 1); step();
    no_push(); step();
    out_ready_i = 0;
    repeat (2) begin put(0, 0, 0, 0, 16, 0); step(); end
    rst_i = 1; no_push(); ld_done_i = 1; ld_done_rd_i = 4;
    step();
    rst_i = 0; ld_done_i = 0;
    chk("mrst_count", 128'(count_o), 128'(0));
    chk("mrst_ready", 128'(in_ready_o), 128'(1));
    put(4, 1, 0, 0, 17, 0); step();
    no_push();
    chk("mrst_valid", 128'(out_valid_o), 128'(1));
    chk("mrst_hazard", 128'(hazard_o), 128'(0));
    out_ready_i = 1; step();

    // Random traffic with hazards, flushes and occasional resets.
    repeat (3000) begin
      if ($urandom_range(99) < 60)
        put(RW'($urandom_range(7)), 1'($urandom), RW'($urandom_range(7)), 1'($urandom),
            RW'($urandom_range(7)), $urandom_range(3) == 0);
      else
        no_push();
      out_ready_i  = $urandom_range(99) < 70;
      ld_done_i    = $urandom_range(99) < 25;
      ld_done_rd_i = RW'($urandom_range(7));
      flush_i      = $urandom_range(99) < 2;
      rst_i        = $urandom_range(999) < 3;
      step();
    end

    // Retire every possible pending load and drain.
    no_push(); flush_i = 0; rst_i = 0; out_ready_i = 1;
    for (int r = 0; r < 32; r++) done(RW'(r));
    repeat (8) step();
    chk("final_exp_empty", 128'(exp_q.size()), 128'(0));
    chk("final_count", 128'(count_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
